// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - AXI4-Lite read master response codes, FSM states and timeout fill word
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } state_t;

  // Only SLVERR and DECERR are failures; EXOKAY is treated as success.
  function automatic logic is_error_resp(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi4_lite_read_master_if.sv
// rtl/axi4_lite_read_master_if.sv - AXI4-Lite read address, data and response channels
interface axi4_lite_read_master_if #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 32
);

  logic [ADDRESS_WIDTH-1:0] read_addr;
  logic                     read_addr_valid;
  logic                     read_addr_ready;
  logic [DATA_WIDTH-1:0]    read_data;
  logic                     read_data_valid;
  logic                     read_data_ready;
  logic [1:0]               read_resp;
  logic                     read_resp_valid;
  logic                     read_resp_ready;

  modport master (
    output read_addr, read_addr_valid, read_data_ready, read_resp_ready,
    input  read_addr_ready, read_data, read_data_valid, read_resp, read_resp_valid
  );

  modport slave (
    input  read_addr, read_addr_valid, read_data_ready, read_resp_ready,
    output read_addr_ready, read_data, read_data_valid, read_resp, read_resp_valid
  );

endinterface

// File: rtl/axi4_read_watchdog.sv
// rtl/axi4_read_watchdog.sv - DATA-phase cycle counter raising expired after TIMEOUT_CYCLES cycles
module axi4_read_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic axi_clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge axi_clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // Counter starts at 0 on the first DATA cycle, so LAST marks the final one.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/axi4_lite_read_master.sv
// rtl/axi4_lite_read_master.sv - single-outstanding AXI4-Lite read master; optional watchdog via AXI4_READ_TIMEOUT_EN
module axi4_lite_read_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     axi_clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_error,
  axi4_lite_read_master_if.master  axi
);

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_nxt;
  logic                     addr_valid_q, addr_valid_nxt;
  logic                     data_ready_q, data_ready_nxt;
  logic                     resp_ready_q, resp_ready_nxt;
  logic                     rsp_valid_q, rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_nxt;
  logic                     rsp_error_q, rsp_error_nxt;
  logic                     got_data_q, got_data_nxt;
  logic                     got_resp_q, got_resp_nxt;
  logic                     data_hs, resp_hs;
  logic                     timeout_expired;

  // Readys are only ever high in DATA, so beats outside DATA never handshake.
  assign data_hs = data_ready_q && axi.read_data_valid;
  assign resp_hs = resp_ready_q && axi.read_resp_valid;

`ifdef AXI4_READ_TIMEOUT_EN
  axi4_read_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .axi_clk (axi_clk),
    .resetn  (resetn),
    .clear   ((state == ADDR) && axi.read_addr_ready),
    .enable  (state == DATA),
    .expired (timeout_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_expired    = 1'b0;
`endif

  always_ff @(posedge axi_clk) begin
    if (!resetn) begin
      state        <= IDLE;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      data_ready_q <= 1'b0;
      resp_ready_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      got_data_q   <= 1'b0;
      got_resp_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr_q       <= addr_nxt;
      addr_valid_q <= addr_valid_nxt;
      data_ready_q <= data_ready_nxt;
      resp_ready_q <= resp_ready_nxt;
      rsp_valid_q  <= rsp_valid_nxt;
      rsp_data_q   <= rsp_data_nxt;
      rsp_error_q  <= rsp_error_nxt;
      got_data_q   <= got_data_nxt;
      got_resp_q   <= got_resp_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr_q;
    addr_valid_nxt = addr_valid_q;
    data_ready_nxt = data_ready_q;
    resp_ready_nxt = resp_ready_q;
    rsp_valid_nxt  = rsp_valid_q;
    rsp_data_nxt   = rsp_data_q;
    rsp_error_nxt  = rsp_error_q;
    got_data_nxt   = got_data_q;
    got_resp_nxt   = got_resp_q;

    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_nxt       = req_addr;
          addr_valid_nxt = 1'b1;
          state_nxt      = ADDR;
        end
      end
      ADDR: begin
        if (axi.read_addr_ready) begin
          addr_valid_nxt = 1'b0;
          data_ready_nxt = 1'b1;
          resp_ready_nxt = 1'b1;
          state_nxt      = DATA;
        end
      end
      DATA: begin
        if (data_hs) begin
          rsp_data_nxt   = axi.read_data;
          data_ready_nxt = 1'b0;
          got_data_nxt   = 1'b1;
        end
        if (resp_hs) begin
          rsp_error_nxt  = is_error_resp(axi.read_resp);
          resp_ready_nxt = 1'b0;
          got_resp_nxt   = 1'b1;
        end
        // A real completion landing on the expiry cycle wins over the timeout.
        if (got_data_nxt && got_resp_nxt) begin
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else if (timeout_expired) begin
          rsp_valid_nxt  = 1'b1;
          rsp_error_nxt  = 1'b1;
          rsp_data_nxt   = DATA_WIDTH'(TIMEOUT_FILL);
          data_ready_nxt = 1'b0;
          resp_ready_nxt = 1'b0;
          state_nxt      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          got_data_nxt  = 1'b0;
          got_resp_nxt  = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready           = (state == IDLE);
  assign rsp_valid           = rsp_valid_q;
  assign rsp_data            = rsp_data_q;
  assign rsp_error           = rsp_error_q;
  assign axi.read_addr       = addr_q;
  assign axi.read_addr_valid = addr_valid_q;
  assign axi.read_data_ready = data_ready_q;
  assign axi.read_resp_ready = resp_ready_q;

endmodule
